// File: rtl/data_receive.sv
// Coherent BPSK / ASK energy-detect bit receiver with integrate-and-dump windows,
// sync-word hunt and MSB-first byte/frame assembly.
module data_receive #(
  parameter int         SPB         = 16,
  parameter int         ACC_WIDTH   = 32,
  parameter logic [7:0] SYNC_WORD   = 8'hA5,
  parameter int         FRAME_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          mod_in,
  input  logic [11:0]          carrier_ref,
  input  logic                 mode_sel,
  input  logic [ACC_WIDTH-1:0] threshold,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [7:0]           rx_byte,
  output logic                 byte_valid,
  output logic                 locked,
  output logic                 frame_done
);

  // state  | meaning
  // HUNT   | shifting decided bits, waiting for SYNC_WORD
  // LOCKED | assembling FRAME_BYTES payload bytes, sync matches ignored

  localparam int CW = $clog2(SPB);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(SPB - 1);
  localparam logic [7:0]    LAST_BYTE   = 8'(FRAME_BYTES - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                 state;
  logic [CW-1:0]          samp_cnt;
  logic signed [11:0]     s_in, s_ref;
  logic                   mode_0, last_0;
  logic signed [23:0]     term;
  logic                   mode_1, last_1;
  logic [ACC_WIDTH-1:0]   acc, sum_q;
  logic                   mode_2, dec_pend;
  logic [7:0]             shreg;
  logic [2:0]             bit_cnt;
  logic [7:0]             byte_cnt;

  logic signed [23:0]     prod;
  logic [11:0]            mag;
  logic [ACC_WIDTH-1:0]   term_ext, acc_next;
  logic                   dec_bit;
  logic [7:0]             shift_next;

  assign prod     = s_in * s_ref;
  // Two's-complement magnitude; -2048 yields 12'h800 read as unsigned 2048.
  assign mag      = s_in[11] ? (~s_in + 12'sd1) : s_in;
  assign term_ext = {{(ACC_WIDTH-24){term[23]}}, term};
  assign acc_next = acc + term_ext;
  assign dec_bit  = mode_2 ? (!sum_q[ACC_WIDTH-1] && (sum_q != '0))
                           : (sum_q > threshold);
  assign shift_next = {shreg[6:0], dec_bit};
  assign locked   = (state == LOCKED);

  // Sample capture and per-term product / magnitude.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt <= '0;
      s_in     <= '0;
      s_ref    <= '0;
      mode_0   <= 1'b0;
      last_0   <= 1'b0;
      term     <= '0;
      mode_1   <= 1'b0;
      last_1   <= 1'b0;
    end else begin
      samp_cnt <= samp_cnt + CW'(1);
      s_in     <= {~mod_in[11], mod_in[10:0]};
      s_ref    <= {~carrier_ref[11], carrier_ref[10:0]};
      mode_0   <= mode_sel;
      last_0   <= (samp_cnt == LAST_SAMPLE);
      term     <= mode_0 ? prod : {12'd0, mag};
      mode_1   <= mode_0;
      last_1   <= last_0;
    end
  end

  // Integrate and dump: the window's last term is folded into the latched sum
  // and the accumulator restarts so the next term begins a fresh window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      sum_q    <= '0;
      mode_2   <= 1'b0;
      dec_pend <= 1'b0;
    end else begin
      dec_pend <= last_1;
      if (last_1) begin
        sum_q  <= acc_next;
        mode_2 <= mode_1;
        acc    <= '0;
      end else begin
        acc    <= acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      if (dec_pend) begin
        bit_out   <= dec_bit;
        bit_valid <= 1'b1;
        shreg     <= shift_next;
        case (state)
          HUNT: begin
            if (shift_next == SYNC_WORD) begin
              state    <= LOCKED;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
          LOCKED: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte    <= shift_next;
              byte_valid <= 1'b1;
              byte_cnt   <= byte_cnt + 8'd1;
              if (byte_cnt == LAST_BYTE) begin
                frame_done <= 1'b1;
                state      <= HUNT;
                shreg      <= '0;
                byte_cnt   <= '0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/data_receive.md
DATA_RECEIVE -- requirements
Module: data_receive

Interface
REQ-001 SHALL have parameter SPB, default 16: samples per bit, power of two, range 4..256.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator width; must be ≥ 24+log2(SPB).
REQ-003 SHALL have parameter SYNC_WORD, default 8'hA5: frame sync pattern, MSB received first.
REQ-004 SHALL have parameter FRAME_BYTES, default 4: payload bytes per frame, range 1..255.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port mod_in, input, 12: received modulated sample, offset binary, mid-scale 2048.
REQ-008 SHALL have port carrier_ref, input, 12: coherent carrier sample, offset binary, aligned with mod_in.
REQ-009 SHALL have port mode_sel, input, 1: 0 = ASK energy detect, 1 = BPSK coherent detect.
REQ-010 SHALL have port threshold, input, ACC_WIDTH: unsigned ASK decision threshold.
REQ-011 SHALL have port bit_out, output, 1: last decided bit.
REQ-012 SHALL have port bit_valid, output, 1: one-cycle strobe per decided bit.
REQ-013 SHALL have port rx_byte, output, 8: assembled payload byte, MSB first.
REQ-014 SHALL have port byte_valid, output, 1: one-cycle strobe with rx_byte.
REQ-015 SHALL have port locked, output, 1: high while in state LOCKED.
REQ-016 SHALL have port frame_done, output, 1: one-cycle strobe after the last payload byte.

Function
REQ-017 SHALL convert both inputs to signed form by inverting the MSB: s = {~x[11], x[10:0]}.
REQ-018 Stage 1 SHALL register term, which is s_in*s_ref (24-bit signed) when mode_sel=1 and |s_in| zero-extended when mode_sel=0.
- |−2048| = 2048; no saturation.
- mode_sel is sampled per clock.
- mode changes mid-bit corrupt only that bit.
REQ-019 Stage 2 SHALL integrate and dump: accumulate term over SPB consecutive terms, sign-extended to ACC_WIDTH.
- On a window's final term, the sum including that term is latched for decision.
- The accumulator reloads with the next term, with no dead cycle.
REQ-020 Windows SHALL be counted by a modulo-SPB sample counter.
- Sample 0 is mod_in captured on the first rising edge after rst deasserts.
- Window k covers samples k*SPB .. k*SPB+SPB-1.
REQ-021 Decision rules:
- BPSK: bit = 1 if latched sum > 0, else 0; exactly 0 decides 0.
- ASK: bit = 1 if latched sum (unsigned) > threshold, else 0.
REQ-022 bit_out/bit_valid SHALL update 3 rising edges after the edge capturing a window's last sample.
- bit_valid is high for exactly 1 cycle per window.
REQ-023 SHALL keep an 8-bit decision shift register; each new bit shifts in at the LSB.
REQ-024 SHALL implement FSM states HUNT and LOCKED:
- HUNT: when the shift register, including the new bit, equals SYNC_WORD, go to LOCKED on that cycle's edge; clear the bit and byte counters.
- LOCKED: assemble 8 bits MSB-first per byte; byte_valid and rx_byte assert on the same edge as the 8th bit's bit_valid.
- LOCKED: after the FRAME_BYTES-th byte, frame_done pulses with that byte_valid, then return to HUNT.
- LOCKED: sync-word matches are ignored.
REQ-025 After returning to HUNT, the shift register SHALL be cleared to 8'h00, so payload bits cannot form a false sync.
REQ-026 locked SHALL be combinationally equal to (state == LOCKED).

Reset
REQ-027 SHALL, on rst low (asynchronous), clear:
- pipeline, accumulator, sample counter, shift register and counters to 0;
- state to HUNT;
- bit_out, bit_valid, rx_byte, byte_valid, frame_done to 0; locked to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no byte_valid or frame_done.
- The first window after release starts at sample 0.

Verification
REQ-029 BPSK polarity: mode_sel=1; bit 1 sent as mod_in=carrier_ref, bit 0 as mod_in=4096−carrier_ref (full-scale sine, SPB=16); send 1,0,1,1.
- bit_out sequence is 1,0,1,1.
- Each bit_valid occurs 3 edges after sample 15, 31, 47, 63.
REQ-030 ASK: mode_sel=1'b0, threshold=32'd8000; bit 1 = full-scale sine, bit 0 = constant 2048; send 0,1.
- bit_out sequence is 0,1.
- Window 0 latched sum is 0.
REQ-031 Frame: send BPSK bits 8'hA5, then bytes 8'h3C, 8'hFF, 8'h00, 8'h81.
- locked rises with the 8th sync bit.
- 4 byte_valid pulses carry 3C, FF, 00, 81.
- frame_done coincides with the 81 strobe; locked then drops.
REQ-032 False sync: send 8'hA4, then 8'hA5 split across a byte boundary after 3 random bits.
- No lock on A4.
- Lock exactly on the completing A5 bit.
REQ-033 Reset mid-frame: pull rst low for 2 cycles after the 2nd payload byte.
- All outputs are 0 immediately.
- No frame_done.
- A new A5 plus 4 bytes is received correctly afterward.
REQ-034 Boundary: BPSK window sum exactly 0 (mod_in=2048 throughout) decides 0.
- Sustained max-magnitude input (2047 × -2048 products) does not overflow ACC_WIDTH=32.
